// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill sequencer: one outstanding L2 line read at a time.
// Streams in-order response beats to the data array and tracks snoops that hit the pending line.
module icache_refill_ctrl #(
    parameter int LA_W   = 33,
    parameter int DATA_W = 128,
    parameter int BEATS  = 4,
    parameter int ID_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       miss_valid,
    output logic                       miss_retry,
    input  logic [LA_W-1:0]            miss_laddr,
    output logic                       l2req_valid,
    input  logic                       l2req_retry,
    output logic [LA_W-1:0]            l2req_laddr,
    output logic [ID_W-1:0]            l2req_id,
    input  logic                       l2rsp_valid,
    output logic                       l2rsp_retry,
    input  logic [ID_W-1:0]            l2rsp_id,
    input  logic [DATA_W-1:0]          l2rsp_data,
    output logic                       fill_valid,
    output logic [LA_W-1:0]            fill_laddr,
    output logic [$clog2(BEATS)-1:0]   fill_beat,
    output logic [DATA_W-1:0]          fill_data,
    output logic                       done_valid,
    output logic [LA_W-1:0]            done_laddr,
    output logic                       done_install,
    input  logic                       snoop_valid,
    input  logic [LA_W-1:0]            snoop_laddr,
    output logic                       err_stray
);

    localparam int CNT_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LA_W-1:0]   pend_laddr;
    logic [ID_W-1:0]   cur_id;
    logic [CNT_W-1:0]  beat_cnt;
    logic              poison;
    logic              miss_accept;
    logic              beat_accept;
    logic              last_beat;
    logic              snoop_hit;

    assign l2rsp_retry = 1'b0;
    assign beat_accept = (state == S_WAIT) && l2rsp_valid && (l2rsp_id == cur_id);
    assign last_beat   = beat_accept && (beat_cnt == CNT_W'(BEATS - 1));
    // A snoop only matters while a refill owns pend_laddr.
    assign snoop_hit   = snoop_valid && (snoop_laddr == pend_laddr) && (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output and next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        miss_accept  = 1'b0;
        miss_retry   = 1'b1;
        l2req_valid  = 1'b0;
        l2req_laddr  = '0;
        l2req_id     = '0;
        done_valid   = 1'b0;
        done_laddr   = '0;
        done_install = 1'b0;
        case (state)
            S_IDLE: begin
                miss_retry = 1'b0;
                if (miss_valid) begin
                    miss_accept = 1'b1;
                    state_nxt   = S_REQ;
                end
            end
            S_REQ: begin
                l2req_valid = 1'b1;
                l2req_laddr = pend_laddr;
                l2req_id    = cur_id;
                if (!l2req_retry) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (last_beat) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done_valid   = 1'b1;
                done_laddr   = pend_laddr;
                // A snoop landing in this very cycle must also block the install.
                done_install = !poison && !snoop_hit;
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_laddr <= '0;
            cur_id     <= '0;
            beat_cnt   <= '0;
            poison     <= 1'b0;
            fill_valid <= 1'b0;
            fill_laddr <= '0;
            fill_beat  <= '0;
            fill_data  <= '0;
            err_stray  <= 1'b0;
        end else begin
            // Suppress the fill when the line was poisoned at or before this acceptance.
            fill_valid <= beat_accept && !poison && !snoop_hit;
            err_stray  <= l2rsp_valid && !beat_accept;

            if (miss_accept) begin
                pend_laddr <= miss_laddr;
                beat_cnt   <= '0;
                poison     <= 1'b0;
            end else if (snoop_hit) begin
                poison <= 1'b1;
            end

            if (beat_accept) begin
                beat_cnt   <= beat_cnt + 1'b1;
                fill_beat  <= beat_cnt;
                fill_data  <= l2rsp_data;
                fill_laddr <= pend_laddr;
            end

            if (last_beat) begin
                cur_id <= cur_id + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: refill sequencing, backpressure, snoops, strays, ID wrap, reset.
module tb_icache_refill_ctrl;

    localparam int LA_W   = 33;
    localparam int DATA_W = 128;
    localparam int BEATS  = 4;
    localparam int ID_W   = 4;
    localparam int CNT_W  = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                miss_valid = 1'b0;
    logic                miss_retry;
    logic [LA_W-1:0]     miss_laddr = '0;
    logic                l2req_valid;
    logic                l2req_retry = 1'b0;
    logic [LA_W-1:0]     l2req_laddr;
    logic [ID_W-1:0]     l2req_id;
    logic                l2rsp_valid = 1'b0;
    logic                l2rsp_retry;
    logic [ID_W-1:0]     l2rsp_id = '0;
    logic [DATA_W-1:0]   l2rsp_data = '0;
    logic                fill_valid;
    logic [LA_W-1:0]     fill_laddr;
    logic [CNT_W-1:0]    fill_beat;
    logic [DATA_W-1:0]   fill_data;
    logic                done_valid;
    logic [LA_W-1:0]     done_laddr;
    logic                done_install;
    logic                snoop_valid = 1'b0;
    logic [LA_W-1:0]     snoop_laddr = '0;
    logic                err_stray;

    int tests_run    = 0;
    int tests_failed = 0;

    icache_refill_ctrl #(
        .LA_W(LA_W), .DATA_W(DATA_W), .BEATS(BEATS), .ID_W(ID_W)
    ) dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_retry(miss_retry), .miss_laddr(miss_laddr),
        .l2req_valid(l2req_valid), .l2req_retry(l2req_retry),
        .l2req_laddr(l2req_laddr), .l2req_id(l2req_id),
        .l2rsp_valid(l2rsp_valid), .l2rsp_retry(l2rsp_retry),
        .l2rsp_id(l2rsp_id), .l2rsp_data(l2rsp_data),
        .fill_valid(fill_valid), .fill_laddr(fill_laddr),
        .fill_beat(fill_beat), .fill_data(fill_data),
        .done_valid(done_valid), .done_laddr(done_laddr), .done_install(done_install),
        .snoop_valid(snoop_valid), .snoop_laddr(snoop_laddr),
        .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Accept a miss, then hold the request under n_retry cycles of L2 backpressure; ends in WAIT.
    task automatic issue_miss(input logic [LA_W-1:0] la, input logic [ID_W-1:0] id, input int n_retry);
        tests_run++;
        if (miss_retry !== 1'b0) begin
            tests_failed++;
            $display("FAIL issue_idle: miss_retry=%b expected 0", miss_retry);
        end
        miss_valid = 1'b1;
        miss_laddr = la;
        step();
        miss_valid = 1'b0;
        miss_laddr = '0;
        for (int k = 0; k <= n_retry; k++) begin
            l2req_retry = (k < n_retry);
            #1;
            tests_run++;
            if (l2req_valid !== 1'b1 || l2req_laddr !== la || l2req_id !== id || miss_retry !== 1'b1) begin
                tests_failed++;
                $display("FAIL l2req cycle %0d: valid=%b laddr=%h id=%0d miss_retry=%b, expected valid=1 laddr=%h id=%0d miss_retry=1",
                         k, l2req_valid, l2req_laddr, l2req_id, miss_retry, la, id);
            end
            step();
        end
        l2req_retry = 1'b0;
    endtask

    // Back-to-back beats from WAIT; optional snoop in the cycle beat 2 is accepted.
    task automatic collect_beats(input logic [LA_W-1:0] la, input logic [ID_W-1:0] id,
                                 input bit snp, input logic [LA_W-1:0] snp_la);
        logic [DATA_W-1:0] d [BEATS];
        bit hit;
        bit exp_v;
        bit exp_done;
        hit = snp && (snp_la == la);
        for (int b = 0; b < BEATS; b++) begin
            d[b] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        for (int b = 0; b <= BEATS; b++) begin
            l2rsp_valid = (b < BEATS);
            l2rsp_id    = id;
            l2rsp_data  = (b < BEATS) ? d[b] : '0;
            snoop_valid = snp && (b == 2);
            snoop_laddr = snp_la;
            #1;
            if (b > 0) begin
                exp_v = !(hit && (b - 1) >= 2);
                tests_run++;
                if (fill_valid !== exp_v ||
                    (exp_v && (fill_beat !== CNT_W'(b - 1) || fill_data !== d[b-1] || fill_laddr !== la))) begin
                    tests_failed++;
                    $display("FAIL fill beat %0d: valid=%b beat=%0d laddr=%h data=%h, expected valid=%b beat=%0d laddr=%h data=%h",
                             b - 1, fill_valid, fill_beat, fill_laddr, fill_data, exp_v, b - 1, la, d[b-1]);
                end
            end
            exp_done = (b == BEATS);
            tests_run++;
            if (done_valid !== exp_done) begin
                tests_failed++;
                $display("FAIL done_valid cycle %0d: got %b expected %b", b, done_valid, exp_done);
            end
            if (exp_done) begin
                tests_run++;
                if (done_laddr !== la || done_install !== !hit) begin
                    tests_failed++;
                    $display("FAIL done payload: laddr=%h install=%b, expected laddr=%h install=%b",
                             done_laddr, done_install, la, !hit);
                end
            end
            step();
        end
        l2rsp_valid = 1'b0;
        snoop_valid = 1'b0;
        #1;
        tests_run++;
        if (miss_retry !== 1'b0 || done_valid !== 1'b0 || fill_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL back_to_idle: miss_retry=%b done_valid=%b fill_valid=%b, expected all 0",
                     miss_retry, done_valid, fill_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (miss_retry !== 1'b0 || l2req_valid !== 1'b0 || l2req_laddr !== '0 || l2req_id !== '0 ||
            fill_valid !== 1'b0 || fill_beat !== '0 || fill_data !== '0 || fill_laddr !== '0 ||
            done_valid !== 1'b0 || done_laddr !== '0 || done_install !== 1'b0 || err_stray !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: some output nonzero (miss_retry=%b l2req_valid=%b fill_valid=%b done_valid=%b err_stray=%b)",
                     miss_retry, l2req_valid, fill_valid, done_valid, err_stray);
        end
        step();
        reset = 1'b0;
        step();
        tests_run++;
        if (l2rsp_retry !== 1'b0 || miss_retry !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: l2rsp_retry=%b miss_retry=%b expected 0 0", l2rsp_retry, miss_retry);
        end
    endtask

    task automatic test_basic();
        issue_miss(33'h1234, 4'd0, 0);
        collect_beats(33'h1234, 4'd0, 1'b0, '0);
    endtask

    task automatic test_backpressure();
        issue_miss(33'h2222, 4'd1, 3);
        collect_beats(33'h2222, 4'd1, 1'b0, '0);
    endtask

    task automatic test_stray();
        l2rsp_valid = 1'b1;
        l2rsp_id    = 4'd5;
        l2rsp_data  = {4{32'hdeadbeef}};
        step();
        l2rsp_valid = 1'b0;
        #1;
        tests_run++;
        if (err_stray !== 1'b1 || fill_valid !== 1'b0 || miss_retry !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_idle: err_stray=%b fill_valid=%b miss_retry=%b, expected 1 0 0",
                     err_stray, fill_valid, miss_retry);
        end
        step();
        tests_run++;
        if (err_stray !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_pulse_width: err_stray=%b expected 0", err_stray);
        end
        issue_miss(33'h4444, 4'd2, 0);
        l2rsp_valid = 1'b1;
        l2rsp_id    = 4'd3;
        l2rsp_data  = {4{32'hbadbad00}};
        step();
        l2rsp_valid = 1'b0;
        #1;
        tests_run++;
        if (err_stray !== 1'b1 || fill_valid !== 1'b0 || miss_retry !== 1'b1) begin
            tests_failed++;
            $display("FAIL stray_wrong_id: err_stray=%b fill_valid=%b miss_retry=%b, expected 1 0 1",
                     err_stray, fill_valid, miss_retry);
        end
        collect_beats(33'h4444, 4'd2, 1'b0, '0);
    endtask

    task automatic test_snoop();
        issue_miss(33'h3333, 4'd3, 0);
        collect_beats(33'h3333, 4'd3, 1'b1, 33'h3333);
        issue_miss(33'h3334, 4'd4, 0);
        collect_beats(33'h3334, 4'd4, 1'b1, 33'h7777);
    endtask

    task automatic test_reset_mid();
        issue_miss(33'h5555, 4'd5, 0);
        for (int b = 0; b < 2; b++) begin
            l2rsp_valid = 1'b1;
            l2rsp_id    = 4'd5;
            l2rsp_data  = {4{32'h11110000 + 32'(b)}};
            step();
        end
        l2rsp_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (miss_retry !== 1'b0 || l2req_valid !== 1'b0 || l2req_laddr !== '0 || l2req_id !== '0 ||
            fill_valid !== 1'b0 || fill_beat !== '0 || fill_data !== '0 || fill_laddr !== '0 ||
            done_valid !== 1'b0 || done_laddr !== '0 || done_install !== 1'b0 || err_stray !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset_mid: outputs not cleared (miss_retry=%b fill_valid=%b fill_beat=%0d fill_laddr=%h)",
                     miss_retry, fill_valid, fill_beat, fill_laddr);
        end
        step();
        step();
        reset = 1'b0;
        step();
        issue_miss(33'h5556, 4'd0, 0);
        collect_beats(33'h5556, 4'd0, 1'b0, '0);
    endtask

    task automatic test_id_wrap();
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            issue_miss(33'h10000 + 33'(i), ID_W'(i), 0);
            collect_beats(33'h10000 + 33'(i), ID_W'(i), 1'b0, '0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stray();
        test_snoop();
        test_reset_mid();
        test_id_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
